sonar_ping_scheduler: RTL
=========================

Name: sonar_ping_scheduler

Overview:
Top-level sequencer for the sonar ping cycle. Replaces the free-running PWM, burst-edge and angle-bounce logic with one FSM that:
- gates the transmit burst;
- blanks transducer ring-down;
- paces ADC SPI triggers during the listen window;
- timestamps the first echo;
- hands one result per ping to the display/velocity path over a valid/ready handshake.

It drives the beamformers' steering angle and provides the per-ping datapath clear pulse.

Parameters:
BURST_CYCLES, 524288, transmit burst length in clk cycles (>=1)
BLANK_CYCLES, 50000, post-burst ring-down window; echoes ignored (>=1)
LISTEN_CYCLES, 16000000, echo/sampling window length (>=1)
SAMPLE_DIV, 100, cycles between ADC triggers in LISTEN (>=2)
ANGLE_WIDTH, 8, signed steering angle width (degrees)
ANGLE_MAX, 30, sweep limit; sweep spans -ANGLE_MAX..+ANGLE_MAX
ANGLE_STEP, 10, sweep step; ANGLE_MAX must be a multiple of it
TIME_WIDTH, 24, timestamp width; must hold BURST+BLANK+LISTEN-1

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  asynchronous, active-low reset
enable_in  input  1  level; continuous sweep pinging while high
single_in  input  1  pulse; one ping at current angle when IDLE
echo_in  input  1  level; thresholded echo detect from receive path
result_ready_in  input  1  consumer accepts result
burst_out  output  1  transmit gate (AND with beamformer tx)
burst_start_out  output  1  1-cycle pulse on first BURST cycle; datapath clear
angle_out  output  ANGLE_WIDTH  signed steering angle, stable for a whole ping
sample_trigger_out  output  1  1-cycle SPI trigger pulse
time_out  output  TIME_WIDTH  cycles since burst start
busy_out  output  1  high in any state other than IDLE
result_valid_out  output  1  result available
result_time_out  output  TIME_WIDTH  first-echo timestamp; all-ones if no hit
result_angle_out  output  ANGLE_WIDTH  angle of the reported ping
result_hit_out  output  1  echo seen in LISTEN

Behaviour:
- Reset (rst_in low, async): state IDLE; all 1-bit outputs 0; time_out 0; angle_out 0; sweep direction up; result_time_out all-ones; result_angle_out 0.
- States and transitions: IDLE -> BURST -> BLANK -> LISTEN -> REPORT -> (BURST | IDLE).
- IDLE -> BURST: enable_in=1, or single_in=1. Both high: continuous mode.
- Entering BURST: time_out=0, burst_start_out=1 for that cycle, burst_out=1 throughout BURST. time_out increments every non-IDLE cycle; REPORT holds its value.
- BURST lasts BURST_CYCLES; BLANK lasts BLANK_CYCLES; LISTEN lasts LISTEN_CYCLES; then REPORT.
- Sampling: sample_trigger_out pulses on LISTEN cycle 0, then every SAMPLE_DIV cycles. Never outside LISTEN. Divider restarts each LISTEN.
- Echo capture: first cycle with echo_in=1 in LISTEN latches time_out and sets hit. Later echoes in the same ping are ignored. echo_in in BURST/BLANK is ignored.
- REPORT: result_valid_out=1 with captured time, angle and hit. Payload is held stable until result_valid_out && result_ready_in; the FSM then leaves REPORT the same cycle and valid drops next cycle.
- Angle sweep: angle_out updates only on REPORT exit after a continuous-mode ping.
  - Bounce sequence: 0,+10,+20,+30,+20,...,-30,-20,...
  - Direction flips on reaching ±ANGLE_MAX.
  - A single-shot ping does not advance the angle.
- REPORT exit goes to BURST if enable_in=1, else IDLE. Deasserting enable mid-ping completes that ping, including REPORT.
- single_in outside IDLE is ignored.
- Width rules: angle arithmetic is signed ANGLE_WIDTH. Counters are sized $clog2(param) and need no saturation given the parameter constraints.

Optional Feature:
SONAR_PING_SCHED_NOSTALL_EN
- Defined: REPORT lasts exactly 1 cycle regardless of result_ready_in.
  - Result is registered into an output holding register with valid; a new result overwrites an unaccepted one.
  - Extra output drop_count_out [15:0] increments (saturating) on each overwrite.
- Undefined: REPORT stalls until handshake as above. No drop_count_out port.

Decomposition:
- Package sonar_pkg: FSM state enum (IDLE, BURST, BLANK, LISTEN, REPORT); default timing constants; signed angle typedef.
- One sub-module, sweep_angle_gen: holds angle and direction registers; advance strobe in; angle out.

Test Plan:
1. Params 8/4/32, SAMPLE_DIV=4, enable=1, ready=1 -> burst_out high for t=0..7; REPORT at t=44; 8 sample pulses at t=12,16,...,40.
2. echo_in high at t=9 and at t=20..25, ready=1 -> result_hit=1, result_time=20.
3. No echo during LISTEN -> result_hit=0, result_time=0xFFFFFF.
4. Eight continuous pings -> result_angle sequence 0,10,20,30,20,10,0,-10.
5. ready held low 10 cycles in REPORT -> payload stable, no new burst_start; burst_start fires the cycle after the handshake.
6. rst_in low mid-LISTEN -> all outputs at reset values immediately; enable=0 mid-LISTEN -> ping completes, REPORT, then IDLE with angle advanced once.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared types and default timing for the sonar ping scheduler.
// Optional build macro honoured by the top: SONAR_PING_SCHED_NOSTALL_EN.
package sonar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BURST,
    ST_BLANK,
    ST_LISTEN,
    ST_REPORT
  } state_t;

  localparam int DEF_BURST_CYCLES  = 524288;
  localparam int DEF_BLANK_CYCLES  = 50000;
  localparam int DEF_LISTEN_CYCLES = 16000000;
  localparam int DEF_SAMPLE_DIV    = 100;
  localparam int DEF_ANGLE_WIDTH   = 8;
  localparam int DEF_ANGLE_MAX     = 30;
  localparam int DEF_ANGLE_STEP    = 10;
  localparam int DEF_TIME_WIDTH    = 24;

  typedef logic signed [DEF_ANGLE_WIDTH-1:0] angle_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sonar_ping_scheduler_if.sv
// Result handshake between the ping scheduler (master) and the display/velocity path (slave).
interface sonar_ping_scheduler_if #(
  parameter int TIME_WIDTH  = 24,
  parameter int ANGLE_WIDTH = 8
);
  logic                          result_valid_out;
  logic                          result_ready_in;
  logic [TIME_WIDTH-1:0]         result_time_out;
  logic signed [ANGLE_WIDTH-1:0] result_angle_out;
  logic                          result_hit_out;

  modport master (
    output result_valid_out, result_time_out, result_angle_out, result_hit_out,
    input  result_ready_in
  );

  modport slave (
    input  result_valid_out, result_time_out, result_angle_out, result_hit_out,
    output result_ready_in
  );
endinterface

// File: rtl/sweep_angle_gen.sv
// Bouncing steering-angle generator: steps by ANGLE_STEP on each advance strobe, reversing at +/-ANGLE_MAX.
module sweep_angle_gen
  import sonar_pkg::*;
#(
  parameter int ANGLE_WIDTH = DEF_ANGLE_WIDTH,
  parameter int ANGLE_MAX   = DEF_ANGLE_MAX,
  parameter int ANGLE_STEP  = DEF_ANGLE_STEP
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          advance_i,
  output logic signed [ANGLE_WIDTH-1:0] angle_o
);

  localparam logic signed [ANGLE_WIDTH-1:0] A_MAX  = ANGLE_WIDTH'(ANGLE_MAX);
  localparam logic signed [ANGLE_WIDTH-1:0] A_STEP = ANGLE_WIDTH'(ANGLE_STEP);

  logic signed [ANGLE_WIDTH-1:0] angle_q, angle_d;
  logic                          dir_up_q, dir_up_d;

  always_comb begin
    angle_d  = angle_q;
    dir_up_d = dir_up_q;
    if (advance_i) begin
      angle_d = dir_up_q ? (angle_q + A_STEP) : (angle_q - A_STEP);
      if (angle_d >= A_MAX)       dir_up_d = 1'b0;
      else if (angle_d <= -A_MAX) dir_up_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      angle_q  <= '0;
      dir_up_q <= 1'b1;
    end else begin
      angle_q  <= angle_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign angle_o = angle_q;

endmodule

// File: rtl/sonar_ping_scheduler.sv
// Sonar ping sequencer: burst gating, ring-down blanking, ADC pacing, first-echo timestamp, result handshake.
// SONAR_PING_SCHED_NOSTALL_EN: one-cycle REPORT into an overwriting holding register with drop counter.
//
//   state  | meaning
//   IDLE   | waiting for enable_in or single_in
//   BURST  | transmit gate open for BURST_CYCLES
//   BLANK  | transducer ring-down, echoes ignored
//   LISTEN | ADC triggers paced, first echo timestamped
//   REPORT | result offered to consumer
module sonar_ping_scheduler
  import sonar_pkg::*;
#(
  parameter int BURST_CYCLES  = DEF_BURST_CYCLES,
  parameter int BLANK_CYCLES  = DEF_BLANK_CYCLES,
  parameter int LISTEN_CYCLES = DEF_LISTEN_CYCLES,
  parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
  parameter int ANGLE_WIDTH   = DEF_ANGLE_WIDTH,
  parameter int ANGLE_MAX     = DEF_ANGLE_MAX,
  parameter int ANGLE_STEP    = DEF_ANGLE_STEP,
  parameter int TIME_WIDTH    = DEF_TIME_WIDTH
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic                          single_in,
  input  logic                          echo_in,
  output logic                          burst_out,
  output logic                          burst_start_out,
  output logic signed [ANGLE_WIDTH-1:0] angle_out,
  output logic                          sample_trigger_out,
  output logic [TIME_WIDTH-1:0]         time_out,
  output logic                          busy_out,
`ifdef SONAR_PING_SCHED_NOSTALL_EN
  output logic [15:0]                   drop_count_out,
`endif
  sonar_ping_scheduler_if.master        res_if
);

  localparam int CNT_W = $clog2(max3(BURST_CYCLES, BLANK_CYCLES, LISTEN_CYCLES) + 1);
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] BURST_LD  = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LD  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LISTEN_LD = CNT_W'(LISTEN_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LD    = DIV_W'(SAMPLE_DIV - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [DIV_W-1:0]        div_q;
  logic [TIME_WIDTH-1:0]   time_q, cap_time_q;
  logic                    hit_q, cont_q;
  logic                    report_done, advance, enter_burst;

`ifdef SONAR_PING_SCHED_NOSTALL_EN
  assign report_done = 1'b1;
`else
  assign report_done = res_if.result_ready_in;
`endif

  always_comb begin
    state_d            = state_q;
    burst_out          = 1'b0;
    sample_trigger_out = 1'b0;
    advance            = 1'b0;
    case (state_q)
      ST_IDLE:   if (enable_in || single_in) state_d = ST_BURST;
      ST_BURST: begin
        burst_out = 1'b1;
        if (cnt_q == '0) state_d = ST_BLANK;
      end
      ST_BLANK:  if (cnt_q == '0) state_d = ST_LISTEN;
      ST_LISTEN: begin
        sample_trigger_out = (div_q == '0);
        if (cnt_q == '0) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (report_done) begin
          advance = cont_q;
          state_d = enable_in ? ST_BURST : ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  assign enter_burst = (state_d == ST_BURST) && (state_q != ST_BURST);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q      <= '0;
      div_q      <= '0;
      time_q     <= '0;
      cap_time_q <= '1;
      hit_q      <= 1'b0;
      cont_q     <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        case (state_d)
          ST_BURST:  cnt_q <= BURST_LD;
          ST_BLANK:  cnt_q <= BLANK_LD;
          ST_LISTEN: cnt_q <= LISTEN_LD;
          default:   cnt_q <= '0;
        endcase
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      // Mode is latched per ping so dropping enable mid-ping still advances the sweep once.
      if (enter_burst) begin
        time_q     <= '0;
        cap_time_q <= '1;
        hit_q      <= 1'b0;
        cont_q     <= enable_in;
      end else if (state_q inside {ST_BURST, ST_BLANK, ST_LISTEN}) begin
        time_q <= time_q + TIME_WIDTH'(1);
      end

      if (state_d == ST_LISTEN && state_q != ST_LISTEN) div_q <= '0;
      else if (state_q == ST_LISTEN) div_q <= (div_q == '0) ? DIV_LD : div_q - DIV_W'(1);

      if (state_q == ST_LISTEN && echo_in && !hit_q) begin
        hit_q      <= 1'b1;
        cap_time_q <= time_q;
      end
    end
  end

  sweep_angle_gen #(
    .ANGLE_WIDTH (ANGLE_WIDTH),
    .ANGLE_MAX   (ANGLE_MAX),
    .ANGLE_STEP  (ANGLE_STEP)
  ) u_sweep (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .advance_i (advance),
    .angle_o   (angle_out)
  );

  assign time_out        = time_q;
  assign busy_out        = (state_q != ST_IDLE);
  assign burst_start_out = (state_q == ST_BURST) && (time_q == '0);

`ifdef SONAR_PING_SCHED_NOSTALL_EN
  logic                          res_valid_q, res_hit_q;
  logic [TIME_WIDTH-1:0]         res_time_q;
  logic signed [ANGLE_WIDTH-1:0] res_angle_q;
  logic [15:0]                   drop_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_time_q  <= '1;
      res_angle_q <= '0;
      drop_q      <= '0;
    end else if (state_q == ST_REPORT) begin
      res_valid_q <= 1'b1;
      res_hit_q   <= hit_q;
      res_time_q  <= cap_time_q;
      res_angle_q <= angle_out;
      if (res_valid_q && !res_if.result_ready_in && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
    end else if (res_valid_q && res_if.result_ready_in) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_if.result_valid_out = res_valid_q;
  assign res_if.result_time_out  = res_time_q;
  assign res_if.result_angle_out = res_angle_q;
  assign res_if.result_hit_out   = res_hit_q;
  assign drop_count_out          = drop_q;
`else
  assign res_if.result_valid_out = (state_q == ST_REPORT);
  assign res_if.result_time_out  = cap_time_q;
  assign res_if.result_angle_out = angle_out;
  assign res_if.result_hit_out   = hit_q;
`endif

endmodule
